gpio_in_filter: RTL
===================

Name: gpio_in_filter

Overview:
Parametrised multi-channel input conditioner for external/asynchronous pins feeding the MCU top.
- Per channel: N-flop synchroniser, run-time-programmable debounce counter, registered clean level output, one-cycle rise/fall event pulses.
- Replaces ad-hoc single-bit d_i -> d_o paths.
- Outputs go to GPIO/IRQ logic.

Parameters:
CH_NUM, 4, number of independent channels
SYNC_STAGES, 2, synchroniser depth (>=2)
CNT_W, 8, debounce counter / threshold width
RST_VAL, 1'b1, reset level of synchroniser flops and d_o (pins idle high)

Ports:
clk_i  in  1  single clock; all logic on rising edge
rstn_i  in  1  synchronous reset, active-high (1 = reset), sampled on clk_i
d_i  in  CH_NUM  raw asynchronous inputs
en_i  in  CH_NUM  per-channel filter enable
thresh_i  in  CNT_W  debounce threshold T in cycles, shared by all channels, quasi-static
d_o  out  CH_NUM  filtered level
rise_o  out  CH_NUM  1-cycle pulse when d_o[i] goes 0->1
fall_o  out  CH_NUM  1-cycle pulse when d_o[i] goes 1->0

Behaviour:
- Reset (rstn_i=1 at an edge):
  - sync flops = RST_VAL.
  - d_o = {CH_NUM{RST_VAL}}.
  - counters = 0.
  - rise_o = fall_o = 0.
  - Reset asserted mid-count aborts the count; no event pulse is produced.
- Synchroniser: SYNC_STAGES flops per channel, always running (including when en_i=0). s[i] is the last stage.
- Effective threshold Te = max(T,1). T=0 behaves as T=1.
- Per channel, per edge, when not in reset:
  - en_i[i]=0: d_o[i] holds; cnt<=0; no pulses.
  - s[i]==d_o[i]: cnt<=0, so any glitch restarts the count.
  - s[i]!=d_o[i] and cnt>=Te-1: d_o[i]<=s[i]; cnt<=0; rise_o/fall_o asserted for exactly this one cycle, according to direction.
  - s[i]!=d_o[i] and cnt<Te-1: cnt<=cnt+1.
- The >= comparison makes a threshold lowered mid-count take effect on the next edge. Raising the threshold extends the count. cnt never exceeds Te-1, so it never wraps.
- Latency: d_i stable from edge N gives d_o change at edge N+SYNC_STAGES+Te-1, i.e. SYNC_STAGES+Te edges after d_i is first sampled.
- A level must persist Te consecutive cycles at s[i] to be accepted. Shorter pulses are rejected.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- rise_o and fall_o of one channel are never both 1.
- Re-enabling a channel (en_i 0->1) starts from cnt=0, so a full Te is needed.
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Package gpio_in_filter_pkg:
  - default CNT_W constant;
  - typedef cnt_t (logic [CNT_W-1:0]);
  - typedef for the per-channel state struct {sync chain, cnt, level}.
- Sub-module gpio_in_filter_ch: one channel (synchroniser + counter + edge pulses). It takes SYNC_STAGES, CNT_W and RST_VAL and is instantiated CH_NUM times in a generate loop.
- Top level contains only the generate loop and port fan-out.

Test Plan:
All scenarios use CH_NUM=4, SYNC_STAGES=2, RST_VAL=1, T=4 unless stated. N is the first edge at which the new d_i value is sampled.
1. rstn_i=1 for 15 cycles while d_i toggles randomly -> d_o=4'hF, rise_o=fall_o=0 throughout. Release with d_i=4'hF -> no output change for 50 cycles.
2. d_i[0] 1->0 at edge N, then stable -> d_o[0]=0 from edge N+5; fall_o[0]=1 only in that cycle; channels 1-3 unchanged. Then d_i[0] 0->1 -> rise_o[0] pulse 6 edges later.
3. d_i[1] low for 3 cycles -> d_o[1] stays 1, no pulse. Low for 4 cycles -> d_o[1] falls, fall_o[1] pulses, then returns high 4 cycles later with rise_o[1].
4. en_i[2]=0, toggle d_i[2] low for 20 cycles -> d_o[2] holds 1, no pulses. Set en_i[2]=1 with d_i[2] low -> fall occurs 4 edges after enable.
5. T=0 -> d_o follows d_i after 3 edges. Separately, T=8 with counter at 5, then T<=2 -> d_o updates on the next edge.
6. Same-edge d_i[0] 0->1 and d_i[3] 1->0 -> rise_o[0] and fall_o[3] in the same cycle. Repeat with rstn_i=1 asserted when cnt=2 -> d_o returns to 4'hF, no pulses, counters 0.

Source files
------------

// File: rtl/gpio_in_filter_pkg.sv
// rtl/gpio_in_filter_pkg.sv - shared constants and types for the GPIO input filter
//
// Purpose: default widths and per-channel state types used by gpio_in_filter
//          and gpio_in_filter_ch.
// Contents:
//   CNT_W_DEF       default debounce counter / threshold width
//   SYNC_STAGES_DEF default synchroniser depth
//   cnt_t           counter type at the default width
//   ch_state_t      per-channel state {sync chain, cnt, level}
package gpio_in_filter_pkg;

    localparam int CNT_W_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    typedef struct packed {
        logic [SYNC_STAGES_DEF-1:0] sync;
        cnt_t                       cnt;
        logic                       level;
    } ch_state_t;

endpackage

// File: rtl/gpio_in_filter_ch.sv
// rtl/gpio_in_filter_ch.sv - one channel: synchroniser, debounce counter, edge pulses
//
// Purpose: conditions one asynchronous pin into a clean registered level with
//          one-cycle rise/fall pulses.
// Ports:
//   clk_i     clock, all logic on rising edge
//   rstn_i    synchronous reset, active-high (1 = reset)
//   d_i       raw asynchronous input
//   en_i      filter enable; when low the level holds and the count clears
//   thresh_i  debounce threshold T (0 behaves as 1)
//   d_o       filtered level
//   rise_o    one-cycle pulse on d_o 0->1
//   fall_o    one-cycle pulse on d_o 1->0
module gpio_in_filter_ch
    import gpio_in_filter_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int   CNT_W       = CNT_W_DEF,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             d_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] thresh_i,
    output logic             d_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W-1:0]       te_m1;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Te-1 with T=0 folded onto T=1, so the counter limit never underflows.
    assign te_m1 = (thresh_i == '0) ? '0 : thresh_i - CNT_W'(1);

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (s == level_q) begin
            // Any return to the accepted level restarts the count.
            cnt_d = '0;
        end else if (cnt_q >= te_m1) begin
            // >= so a threshold lowered mid-count takes effect at once.
            level_d = s;
            cnt_d   = '0;
            rise_d  = s;
            fall_d  = ~s;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            sync_q  <= {SYNC_STAGES{RST_VAL}};
            cnt_q   <= '0;
            level_q <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign d_o    = level_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/gpio_in_filter.sv
// rtl/gpio_in_filter.sv - multi-channel GPIO input conditioner
//
// Purpose: CH_NUM independent synchronise + debounce + edge-detect channels.
// Ports:
//   clk_i     clock, all logic on rising edge
//   rstn_i    synchronous reset, active-high (1 = reset)
//   d_i       raw asynchronous inputs, one per channel
//   en_i      per-channel filter enable
//   thresh_i  debounce threshold T shared by all channels
//   d_o       filtered levels
//   rise_o    one-cycle pulses on d_o 0->1
//   fall_o    one-cycle pulses on d_o 1->0
module gpio_in_filter
    import gpio_in_filter_pkg::*;
#(
    parameter int   CH_NUM      = 4,
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int   CNT_W       = CNT_W_DEF,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [CH_NUM-1:0] d_i,
    input  logic [CH_NUM-1:0] en_i,
    input  logic [CNT_W-1:0]  thresh_i,
    output logic [CH_NUM-1:0] d_o,
    output logic [CH_NUM-1:0] rise_o,
    output logic [CH_NUM-1:0] fall_o
);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        gpio_in_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .RST_VAL     (RST_VAL)
        ) u_ch (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .d_i      (d_i[i]),
            .en_i     (en_i[i]),
            .thresh_i (thresh_i),
            .d_o      (d_o[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i])
        );
    end

endmodule
